// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32I data-memory access controller.
// Handles byte/halfword/word loads with sign or zero extension and performs
// sub-word stores as read-modify-write on a word-wide RAM without byte enables.
// All core- and RAM-facing outputs are registered.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [31:0]           addr,
  input  logic [31:0]           write_data,
  input  logic [3:0]            sign_mask,
  output logic [31:0]           read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_e;

  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_HALF = 3'b011;
  localparam logic [2:0] SZ_WORD = 3'b111;

  // Latched request attributes
  state_e                state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [3:0]            mask_q, mask_d;
  logic                  is_store_q, is_store_d;

  // Registered outputs
  logic [31:0]           read_data_q, read_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;

  // Address bits above the RAM window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  // Size code must be legal and the address naturally aligned for that size.
  function automatic logic req_legal(input logic [2:0] size, input logic [1:0] a_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (a_lo[0] == 1'b0);
      SZ_WORD: ok = (a_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [3:0]  mask);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (mask[2:0])
      SZ_BYTE: r = mask[3] ? {{24{b[7]}}, b} : {24'h000000, b};
      SZ_HALF: r = mask[3] ? {{16{h[15]}}, h} : {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the new byte or halfword onto the old RAM word.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [15:0] data,
                                              input logic [1:0]  lane,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old;
    case (mask[2:0])
      SZ_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          2'd3:    r[31:24] = data[7:0];
          default: r        = old;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          r[31:16] = data;
        end else begin
          r[15:0] = data;
        end
      end
      default: r = old;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    is_store_d  = is_store_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (memread || memwrite) begin
          if ((memread && memwrite) || !req_legal(sign_mask[2:0], addr[1:0])) begin
            // Rejected before any RAM access; mem_addr is left untouched.
            error_d = 1'b1;
            state_d = S_ERR;
          end else begin
            lane_d     = addr[1:0];
            wdata_d    = write_data[15:0];
            mask_d     = sign_mask;
            is_store_d = memwrite;
            mem_addr_d = addr[ADDR_WIDTH+1:2];
            if (memwrite && (sign_mask[2:0] == SZ_WORD)) begin
              // Full-word store needs no read: write straight away.
              mem_wdata_d = write_data;
              mem_we_d    = 1'b1;
              state_d     = S_WR;
            end else begin
              mem_re_d = 1'b1;
              state_d  = S_RD;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (is_store_q) begin
          mem_wdata_d = store_merge(mem_rdata, wdata_q, lane_q, mask_q);
          mem_we_d    = 1'b1;
          state_d     = S_WR;
        end else begin
          read_data_d = load_extend(mem_rdata, lane_q, mask_q);
          done_d      = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_WR: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drops RAM strobes immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'b00;
      wdata_q     <= 16'h0000;
      mask_q      <= 4'h0;
      is_store_q  <= 1'b0;
      read_data_q <= 32'h0000_0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      is_store_q  <= is_store_d;
      read_data_q <= read_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign read_data = read_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl with a behavioural word RAM and a
// scoreboard queue of expected load results.
module tb_data_mem_ctrl;

  logic        clk;
  logic        reset_n;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];
  logic [31:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [31:0] last_rd = 32'h0;

  data_mem_ctrl #(.ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .memread    (memread),
    .memwrite   (memwrite),
    .addr       (addr),
    .write_data (write_data),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM: read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (mem_re) re_cnt = re_cnt + 1;
    if (mem_we) we_cnt = we_cnt + 1;
    if (done)   done_cnt = done_cnt + 1;
    if (error)  err_cnt = err_cnt + 1;
  end

  // Drive one request, release it after the accepting edge, and report the
  // cycle index (1 = between E0 and E1) at which done/error were seen.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m,
                        output int done_k, output int err_k);
    @(negedge clk);
    memread = rd; memwrite = wr; addr = a; write_data = wd; sign_mask = m;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    done_k = 0; err_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done && done_k == 0) done_k = k;
      if (error && err_k == 0) err_k = k;
      if (!busy && (done_k != 0 || err_k != 0)) break;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; memread = 1'b0; memwrite = 1'b0;
    addr = 32'h0; write_data = 32'h0; sign_mask = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({read_data, busy, done, error, mem_addr, mem_re, mem_we, mem_wdata} !== 79'h0) begin
      errors++;
      $display("FAIL reset_values: got rd=%h busy=%b done=%b err=%b ma=%h re=%b we=%b wd=%h, want all zero",
               read_data, busy, done, error, mem_addr, mem_re, mem_we, mem_wdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    int dk, ek, re0, we0;
    re0 = re_cnt; we0 = we_cnt;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b0111, dk, ek);
    checks++;
    if (dk !== 2) begin errors++; $display("FAIL sw_done_latency: got %0d want 2", dk); end
    checks++;
    if ((we_cnt - we0) !== 1 || (re_cnt - re0) !== 0) begin
      errors++; $display("FAIL sw_strobes: got we=%0d re=%0d want we=1 re=0", we_cnt - we0, re_cnt - re0);
    end
    checks++;
    if (ram[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_ram: got %h want deadbeef", ram[4]); end
    checks++;
    if (read_data !== last_rd) begin errors++; $display("FAIL sw_keeps_rd: got %h want %h", read_data, last_rd); end

    exp_q.push_back(32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'b0111, dk, ek);
    checks++;
    if (dk !== 3) begin errors++; $display("FAIL lw_done_latency: got %0d want 3", dk); end
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (read_data !== e) begin errors++; $display("FAIL lw_data: got %h want %h", read_data, e); end
      last_rd = e;
    end
  endtask

  task automatic test_extension();
    logic [31:0] addrs [7];
    logic [3:0]  masks [7];
    logic [31:0] exps  [7];
    int dk, ek;
    addrs = '{32'h41, 32'h42, 32'h42, 32'h42, 32'h42, 32'h43, 32'h40};
    masks = '{4'b1001, 4'b1001, 4'b0001, 4'b1011, 4'b0011, 4'b1001, 4'b0111};
    exps  = '{32'h0000007F, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF80F0,
              32'h000080F0, 32'hFFFFFF80, 32'h80F07F01};
    access(1'b0, 1'b1, 32'h40, 32'h80F07F01, 4'b0111, dk, ek);
    for (int i = 0; i < 7; i++) begin
      logic [31:0] e;
      exp_q.push_back(exps[i]);
      access(1'b1, 1'b0, addrs[i], 32'h0, masks[i], dk, ek);
      e = exp_q.pop_front();
      checks++;
      if (dk !== 3 || read_data !== e) begin
        errors++;
        $display("FAIL ext_load_%0d: got data=%h done_k=%0d want data=%h done_k=3", i, read_data, dk, e);
      end
      last_rd = e;
    end
  endtask

  task automatic test_rmw();
    int dk, ek, re0, we0;
    access(1'b0, 1'b1, 32'h20, 32'h11223344, 4'b0111, dk, ek);
    re0 = re_cnt; we0 = we_cnt;
    access(1'b0, 1'b1, 32'h23, 32'h123456AA, 4'b0001, dk, ek);
    checks++;
    if (dk !== 4) begin errors++; $display("FAIL sb_done_latency: got %0d want 4", dk); end
    checks++;
    if ((we_cnt - we0) !== 1 || (re_cnt - re0) !== 1) begin
      errors++; $display("FAIL sb_strobes: got we=%0d re=%0d want 1 1", we_cnt - we0, re_cnt - re0);
    end
    checks++;
    if (ram[8] !== 32'hAA223344) begin errors++; $display("FAIL sb_ram: got %h want aa223344", ram[8]); end

    re0 = re_cnt; we0 = we_cnt;
    access(1'b0, 1'b1, 32'h20, 32'hFFFF5566, 4'b0011, dk, ek);
    checks++;
    if ((we_cnt - we0) !== 1 || (re_cnt - re0) !== 1 || dk !== 4) begin
      errors++; $display("FAIL sh_strobes: got we=%0d re=%0d done_k=%0d want 1 1 4", we_cnt - we0, re_cnt - re0, dk);
    end
    checks++;
    if (ram[8] !== 32'hAA225566) begin errors++; $display("FAIL sh_ram: got %h want aa225566", ram[8]); end
    checks++;
    if (read_data !== last_rd) begin errors++; $display("FAIL rmw_keeps_rd: got %h want %h", read_data, last_rd); end
  endtask

  task automatic test_errors();
    bit          rds [4];
    bit          wrs [4];
    logic [31:0] as  [4];
    logic [3:0]  ms  [4];
    int dk, ek, re0, we0;
    rds = '{1'b1, 1'b1, 1'b1, 1'b1};
    wrs = '{1'b0, 1'b0, 1'b0, 1'b1};
    as  = '{32'h01, 32'h02, 32'h00, 32'h10};
    ms  = '{4'b1011, 4'b0111, 4'b0000, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      re0 = re_cnt; we0 = we_cnt;
      access(rds[i], wrs[i], as[i], 32'h0BAD0BAD, ms[i], dk, ek);
      checks++;
      if (ek !== 1 || dk !== 0 || (re_cnt - re0) !== 0 || (we_cnt - we0) !== 0 || read_data !== last_rd) begin
        errors++;
        $display("FAIL err_case_%0d: got err_k=%0d done_k=%0d re=%0d we=%0d rd=%h want 1 0 0 0 %h",
                 i, ek, dk, re_cnt - re0, we_cnt - we0, read_data, last_rd);
      end
    end
    checks++;
    if (ram[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_ram: got %h want deadbeef", ram[4]); end
  endtask

  task automatic test_reset_mid_rmw();
    int dk, ek;
    access(1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'b0111, dk, ek);
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h31; write_data = 32'h00000055; sign_mask = 4'b0001;
    @(posedge clk); #1;            // E0: accepted, now in RD
    memwrite = 1'b0;
    @(posedge clk); #2;            // E1: now in RD_WAIT
    reset_n = 1'b0;
    #1;
    checks++;
    if ({read_data, busy, done, error, mem_addr, mem_re, mem_we, mem_wdata} !== 79'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got rd=%h busy=%b ma=%h re=%b we=%b wd=%h want all zero",
               read_data, busy, mem_addr, mem_re, mem_we, mem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (ram[12] !== 32'hCAFEF00D) begin errors++; $display("FAIL midreset_ram: got %h want cafef00d", ram[12]); end
    exp_q.push_back(32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h30, 32'h0, 4'b0111, dk, ek);
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dk !== 3 || read_data !== e) begin
        errors++; $display("FAIL after_reset_load: got %h done_k=%0d want %h 3", read_data, dk, e);
      end
      last_rd = e;
    end
  endtask

  task automatic test_busy_holdoff();
    int re0, we0, d0;
    logic [31:0] e;
    re0 = re_cnt; we0 = we_cnt; d0 = done_cnt;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    memread = 1'b1; addr = 32'h10; sign_mask = 4'b0111;
    @(posedge clk); #1;
    memread = 1'b0;
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h10; write_data = 32'h0; sign_mask = 4'b0111;
    @(posedge clk); #1;
    memwrite = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if ((done_cnt - d0) !== 1 || (we_cnt - we0) !== 0 || (re_cnt - re0) !== 1) begin
      errors++;
      $display("FAIL holdoff_counts: got done=%0d we=%0d re=%0d want 1 0 1", done_cnt - d0, we_cnt - we0, re_cnt - re0);
    end
    e = exp_q.pop_front();
    checks++;
    if (read_data !== e || ram[4] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL holdoff_data: got rd=%h ram=%h want %h deadbeef", read_data, ram[4], e);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_extension();
    test_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_busy_holdoff();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
